// File: rtl/trace_render_if.sv
// Pixel-stream, sample-RAM and VGA colour signals shared between the
// sync/RAM side (master) and the trace renderer (slave).
interface trace_render_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic [7:0] rddata;
    logic       capture_done;
    logic [7:0] level;
    logic [9:0] rdaddress;
    logic       hold;
    logic       R_out;
    logic       G_out;
    logic       B_out;

    modport master (
        output x, y, video_on, rddata, capture_done, level,
        input  rdaddress, hold, R_out, G_out, B_out
    );

    modport slave (
        input  x, y, video_on, rddata, capture_done, level,
        output rdaddress, hold, R_out, G_out, B_out
    );
endinterface

// File: rtl/trace_render.sv
// Oscilloscope display renderer: reads one sample per column, draws a connected
// green trace, a red trigger-level marker and a blue graticule on 1-bit VGA.
module trace_render #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int GRID_X   = 64,
    parameter int GRID_Y   = 60,
    parameter int Y_OFFSET = 112
) (
    input  logic          clk,
    input  logic          rst,
    trace_render_if.slave bus
);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE - 1);
    localparam logic [9:0] GX_TOP_C = 10'(GRID_X - 1);
    localparam logic [9:0] GY_TOP_C = 10'(GRID_Y - 1);
    localparam logic [9:0] Y_TOP_C  = 10'(Y_OFFSET + 255);

    typedef enum logic [0:0] {IDLE = 1'b0, VALID = 1'b1} state_t;

    state_t     state_r;
    logic       pend_r;
    logic       hold_r;
    logic [9:0] rdaddress_r;
    logic [9:0] x_d1_r, y_d1_r, x_d2_r, y_d2_r;
    logic       von_d1_r, von_d2_r;
    logic [9:0] prev_ys_r;
    logic [9:0] gx_r, gy_r;
    logic [2:0] rgb_r;

    logic [9:0] ys_s, prev_s, lo_s, hi_s, marker_row_s;
    logic       trace_s, marker_s, grat_s;

    assign bus.rdaddress = rdaddress_r;
    assign bus.hold      = hold_r;
    assign bus.R_out     = rgb_r[2];
    assign bus.G_out     = rgb_r[1];
    assign bus.B_out     = rgb_r[0];

    // Stage-2 decode: screen row of the sample, segment span and overlay hits.
    always_comb begin
        ys_s         = Y_TOP_C - {2'b00, bus.rddata};
        marker_row_s = Y_TOP_C - {2'b00, bus.level};
        if (x_d2_r == 10'd0) begin
            prev_s = ys_s;
        end else begin
            prev_s = prev_ys_r;
        end
        if (prev_s < ys_s) begin
            lo_s = prev_s;
            hi_s = ys_s;
        end else begin
            lo_s = ys_s;
            hi_s = prev_s;
        end
        trace_s  = (state_r == VALID) && (y_d2_r >= lo_s) && (y_d2_r <= hi_s);
        marker_s = (y_d2_r == marker_row_s);
        grat_s   = (gx_r == 10'd0) || (gy_r == 10'd0) ||
                   (x_d2_r == H_LAST_C) || (y_d2_r == V_LAST_C);
    end

    // Address issue and position/blanking delay line matching the RAM latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdaddress_r <= 10'd0;
            x_d1_r      <= 10'd0;
            y_d1_r      <= 10'd0;
            von_d1_r    <= 1'b0;
            x_d2_r      <= 10'd0;
            y_d2_r      <= 10'd0;
            von_d2_r    <= 1'b0;
            prev_ys_r   <= 10'd0;
        end else begin
            if (bus.x < H_ACT_C) begin
                rdaddress_r <= bus.x;
            end
            x_d1_r   <= bus.x;
            y_d1_r   <= bus.y;
            von_d1_r <= bus.video_on;
            x_d2_r   <= x_d1_r;
            y_d2_r   <= y_d1_r;
            von_d2_r <= von_d1_r;
            if (von_d2_r) begin
                prev_ys_r <= ys_s;
            end
        end
    end

    // Graticule pitch counters track x_d2/y_d2 modulo the grid pitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gx_r <= 10'd0;
            gy_r <= 10'd0;
        end else begin
            if (x_d1_r == 10'd0 || gx_r == GX_TOP_C) begin
                gx_r <= 10'd0;
            end else begin
                gx_r <= gx_r + 10'd1;
            end
            if (y_d1_r == 10'd0) begin
                gy_r <= 10'd0;
            end else if (y_d1_r != y_d2_r) begin
                gy_r <= (gy_r == GY_TOP_C) ? 10'd0 : gy_r + 10'd1;
            end
        end
    end

    // Capture FSM and hold; a capture seen mid-frame is armed and only takes
    // effect in vertical blanking so trace and hold start cleanly at line 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            pend_r  <= 1'b0;
            hold_r  <= 1'b0;
        end else begin
            hold_r <= (state_r == VALID) && (bus.y < V_ACT_C);
            case (state_r)
                IDLE: begin
                    if ((bus.capture_done || pend_r) && (bus.y >= V_ACT_C)) begin
                        state_r <= VALID;
                        pend_r  <= 1'b0;
                    end else if (bus.capture_done) begin
                        pend_r <= 1'b1;
                    end
                end
                VALID: begin
                    state_r <= VALID;
                end
                default: begin
                    state_r <= IDLE;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    // Colour select: trace over marker over graticule, black outside video.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_r <= 3'b000;
        end else if (!von_d2_r) begin
            rgb_r <= 3'b000;
        end else if (trace_s) begin
            rgb_r <= 3'b010;
        end else if (marker_s) begin
            rgb_r <= 3'b100;
        end else if (grat_s) begin
            rgb_r <= 3'b001;
        end else begin
            rgb_r <= 3'b000;
        end
    end
endmodule

// File: tb/tb_trace_render.sv
// Directed bench for trace_render: raster stimulus, behavioural RAM, and a
// pixel scoreboard checked three clocks after each driven pixel.
module tb_trace_render;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trace_render_if bus ();

    trace_render dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:1023];
    always_ff @(posedge clk) bus.rddata <= mem[bus.rdaddress];

    logic [2:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;
    bit         m_valid = 1'b0;
    bit         m_pend  = 1'b0;
    logic [7:0] lvl     = 8'h40;
    int         full_q [$];

    function automatic logic [2:0] pix_exp(int x, int y);
        int ys, pv, lo, hi;
        if (x >= 640 || y >= 480) return 3'b000;
        ys = 367 - int'(mem[x]);
        pv = (x == 0) ? ys : 367 - int'(mem[x-1]);
        lo = (ys < pv) ? ys : pv;
        hi = (ys < pv) ? pv : ys;
        if (m_valid && y >= lo && y <= hi) return 3'b010;
        if (y == 367 - int'(lvl)) return 3'b100;
        if (x % 64 == 0 || y % 60 == 0 || x == 639 || y == 479) return 3'b001;
        return 3'b000;
    endfunction

    task automatic step(input int x, input int y, input bit cd);
        logic [2:0] e;
        bit hold_want;
        @(negedge clk);
        bus.x            = 10'(x);
        bus.y            = 10'(y);
        bus.video_on     = (x < 640 && y < 480);
        bus.capture_done = cd;
        exp_q.push_back(pix_exp(x, y));
        hold_want = m_valid && (y < 480);
        if (!m_valid) begin
            if ((cd || m_pend) && y >= 480) begin
                m_valid = 1'b1;
                m_pend  = 1'b0;
            end else if (cd) begin
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        total++;
        assert (bus.hold === hold_want) else begin
            bad++;
            $error("FAIL hold x=%0d y=%0d got=%b want=%b", x, y, bus.hold, hold_want);
        end
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            total++;
            assert ({bus.R_out, bus.G_out, bus.B_out} === e) else begin
                bad++;
                $error("FAIL rgb (drive x=%0d y=%0d is newest) got=%b want=%b",
                       x, y, {bus.R_out, bus.G_out, bus.B_out}, e);
            end
        end
    endtask

    task automatic do_reset(input int n, input int x0, input int y);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst              = 1'b0;
            bus.x            = 10'(x0 + i);
            bus.y            = 10'(y);
            bus.video_on     = (x0 + i < 640 && y < 480);
            bus.capture_done = 1'b0;
            @(posedge clk);
            #1;
            total++;
            assert (bus.hold === 1'b0) else begin
                bad++;
                $error("FAIL rst_hold got=%b want=0", bus.hold);
            end
            total++;
            assert (bus.rdaddress === 10'd0) else begin
                bad++;
                $error("FAIL rst_rdaddress got=%0d want=0", bus.rdaddress);
            end
            total++;
            assert ({bus.R_out, bus.G_out, bus.B_out} === 3'b000) else begin
                bad++;
                $error("FAIL rst_rgb got=%b want=000", {bus.R_out, bus.G_out, bus.B_out});
            end
        end
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        m_valid = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic run_line(input int y, input int xmax, input int cd_x);
        for (int x = 0; x <= xmax; x++) step(x, y, x == cd_x);
        for (int b = 0; b < 4; b++) step(640 + b, y, 1'b0);
        if (xmax == 639) begin
            total++;
            assert (bus.rdaddress === 10'd639) else begin
                bad++;
                $error("FAIL no_addr_past_edge y=%0d got=%0d want=639", y, bus.rdaddress);
            end
        end
    endtask

    function automatic bit is_full(int y);
        foreach (full_q[i]) if (full_q[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_frame(input int cd_line, input int cd_x);
        for (int y = 0; y < 482; y++)
            run_line(y, is_full(y) ? 639 : 2, (y == cd_line) ? cd_x : -1);
    endtask

    initial begin
        rst              = 1'b0;
        bus.x            = 10'd0;
        bus.y            = 10'd0;
        bus.video_on     = 1'b0;
        bus.capture_done = 1'b0;
        bus.level        = lvl;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h80;

        // power-up reset, then an IDLE frame with a capture arriving in line 200
        do_reset(4, 0, 0);
        full_q = '{0, 60, 200, 239, 303, 479};
        run_frame(200, 1);

        // flat trace with marker on the same row; second capture is ignored
        lvl = 8'h80; bus.level = lvl;
        full_q = '{0, 239, 479};
        run_frame(100, 5);

        // marker below the trace, red wins over graticule
        lvl = 8'h40; bus.level = lvl;
        full_q = '{239, 303};
        run_frame(-1, -1);

        // step between columns 99 and 100
        for (int i = 0; i < 100; i++) mem[i] = 8'h00;
        for (int i = 100; i < 640; i++) mem[i] = 8'hFF;
        full_q = '{111, 112, 200, 367, 368};
        run_frame(-1, -1);

        // mid-frame reset during a visible line; the sync generator restarts too
        full_q = '{};
        for (int y = 0; y < 239; y++) run_line(y, 2, -1);
        for (int x = 0; x <= 300; x++) step(x, 239, 1'b0);
        do_reset(4, 301, 239);
        full_q = '{0, 112, 367, 479};
        run_frame(-1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
